// File: rtl/dt_repack_if.sv
// rtl/dt_repack_if.sv - control and memory bus bundle for the result-map repacker
//
// Signals:
//   start     frame start request (into the repacker)
//   busy      frame in progress
//   done      frame complete, held until the next accepted start or reset
//   res_rd    res memory read enable
//   res_addr  res memory pixel address, row*128+col
//   res_di    res memory read data (combinational read of res_addr)
//   sti_wr    sti memory write strobe, one cycle per word
//   sti_addr  sti word address
//   sti_do    packed sti word, bit 15 = lowest pixel address
// Modports: master = repacker side, slave = memory/controller side.
`timescale 1ns/1ps
interface dt_repack_if;
    logic        start;
    logic        busy;
    logic        done;
    logic        res_rd;
    logic [13:0] res_addr;
    logic [7:0]  res_di;
    logic        sti_wr;
    logic [9:0]  sti_addr;
    logic [15:0] sti_do;

    modport master (
        input  start, res_di,
        output busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do
    );

    modport slave (
        output start, res_di,
        input  busy, done, res_rd, res_addr, sti_wr, sti_addr, sti_do
    );
endinterface

// File: rtl/dt_repack.sv
// rtl/dt_repack.sv - thresholds a 128x128 8-bit result map into 1024 packed 16-bit sti words
//
// Parameter:
//   THRESH  pixel bit = 1 iff res_di > THRESH (unsigned)
// Ports:
//   clk     sole clock, rising edge
//   reset   synchronous active-high reset
//   bus     dt_repack_if.master: start/busy/done control, res read port, sti write port
//
// Timing: the start-accept edge (E0) issues res_addr 0; every following edge
// samples the pixel at the address issued on the previous edge, so pixel k-1
// lands at edge Ek. Word m-1 is written on edge E16m and done rises at E16385.
`timescale 1ns/1ps
module dt_repack #(
    parameter logic [7:0] THRESH = 8'd0
) (
    input  logic        clk,
    input  logic        reset,
    dt_repack_if.master bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        FIN   = 2'd3
    } state_t;

    localparam logic [13:0] LAST_ADDR = 14'd16383;

    state_t      state;
    logic [15:0] acc;

    logic        pix_bit;
    logic [15:0] pix_mask;
    logic [15:0] acc_next;
    logic        sampling;

    // res_addr still holds the address of the pixel currently on res_di,
    // so its low nibble selects the bit position inside the word.
    assign pix_bit  = (bus.res_di > THRESH);
    assign pix_mask = 16'h8000 >> bus.res_addr[3:0];
    assign acc_next = pix_bit ? (acc | pix_mask) : acc;

    // FLUSH samples exactly once (the last pixel), flagged by res_rd still high.
    assign sampling = (state == RUN) || ((state == FLUSH) && bus.res_rd);

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            bus.busy     <= 1'b0;
            bus.done     <= 1'b0;
            bus.res_rd   <= 1'b0;
            bus.res_addr <= '0;
            bus.sti_wr   <= 1'b0;
            bus.sti_addr <= '0;
            bus.sti_do   <= '0;
            acc          <= '0;
        end else begin
            bus.sti_wr <= 1'b0;

            if (sampling) begin
                if (bus.res_addr[3:0] == 4'hF) begin
                    bus.sti_wr   <= 1'b1;
                    bus.sti_addr <= bus.res_addr[13:4];
                    bus.sti_do   <= acc_next;
                    acc          <= '0;
                end else begin
                    acc <= acc_next;
                end
            end

            case (state)
                IDLE, FIN: begin
                    if (bus.start) begin
                        state        <= RUN;
                        bus.busy     <= 1'b1;
                        bus.done     <= 1'b0;
                        bus.res_rd   <= 1'b1;
                        bus.res_addr <= '0;
                        acc          <= '0;
                    end
                end
                RUN: begin
                    // Issuing the final address moves to FLUSH, so res_addr
                    // stops at LAST_ADDR instead of wrapping.
                    bus.res_addr <= bus.res_addr + 14'd1;
                    if (bus.res_addr == LAST_ADDR - 14'd1) begin
                        state <= FLUSH;
                    end
                end
                FLUSH: begin
                    if (bus.res_rd) begin
                        bus.res_rd <= 1'b0;
                    end else begin
                        state    <= FIN;
                        bus.busy <= 1'b0;
                        bus.done <= 1'b1;
                    end
                end
                default: begin
                    state      <= IDLE;
                    bus.busy   <= 1'b0;
                    bus.res_rd <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dt_repack.sv
// tb/tb_dt_repack.sv - scoreboard bench for dt_repack at THRESH 0, 3 and 255
`timescale 1ns/1ps
module tb_dt_repack;

    logic clk = 1'b0;
    logic reset;
    logic start;
    always #5 clk = ~clk;

    dt_repack_if b0 ();
    dt_repack_if b1 ();
    dt_repack_if b2 ();

    dt_repack #(.THRESH(8'd0))   u0 (.clk(clk), .reset(reset), .bus(b0));
    dt_repack #(.THRESH(8'd3))   u1 (.clk(clk), .reset(reset), .bus(b1));
    dt_repack #(.THRESH(8'd255)) u2 (.clk(clk), .reset(reset), .bus(b2));

    logic [7:0] mem [16384];

    assign b0.start  = start;
    assign b1.start  = start;
    assign b2.start  = start;
    assign b0.res_di = mem[b0.res_addr];
    assign b1.res_di = mem[b1.res_addr];
    assign b2.res_di = mem[b2.res_addr];

    int     n_chk  = 0;
    int     n_fail = 0;
    longint cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [9:0]  addr;
        logic [15:0] d0;
        logic [15:0] d1;
        logic [15:0] d2;
    } exp_t;

    exp_t exp_q[$];

    function automatic void check(string name, logic [31:0] act, logic [31:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endfunction

    // Reference: word w holds pixels 16w..16w+15, first pixel in bit 15.
    function automatic logic [15:0] ref_word(int w, int t);
        logic [15:0] r;
        r = '0;
        for (int j = 0; j < 16; j++) begin
            r[15 - j] = (int'(mem[16 * w + j]) > t);
        end
        return r;
    endfunction

    task automatic push_frame();
        exp_t e;
        for (int w = 0; w < 1024; w++) begin
            e.addr = 10'(w);
            e.d0   = ref_word(w, 0);
            e.d1   = ref_word(w, 3);
            e.d2   = ref_word(w, 255);
            exp_q.push_back(e);
        end
    endtask

    // Monitor: pops one expected word per write, checks frame latency and count.
    exp_t   e_mon;
    logic   prev_busy = 1'b0;
    logic   prev_done = 1'b0;
    longint start_cyc = 0;
    int     n_wr      = 0;

    always @(negedge clk) begin
        if (!reset) begin
            if (b0.sti_wr || b1.sti_wr || b2.sti_wr) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_sti_wr", 32'd1, 32'd0);
                end else begin
                    e_mon = exp_q.pop_front();
                    n_wr++;
                    check("sti_wr_all", {29'd0, b0.sti_wr, b1.sti_wr, b2.sti_wr}, 32'd7);
                    check("sti_addr_t0", 32'(b0.sti_addr), 32'(e_mon.addr));
                    check("sti_addr_t3", 32'(b1.sti_addr), 32'(e_mon.addr));
                    check("sti_addr_t255", 32'(b2.sti_addr), 32'(e_mon.addr));
                    check("sti_do_t0", 32'(b0.sti_do), 32'(e_mon.d0));
                    check("sti_do_t3", 32'(b1.sti_do), 32'(e_mon.d1));
                    check("sti_do_t255", 32'(b2.sti_do), 32'(e_mon.d2));
                end
            end
            if (b0.busy && !prev_busy) begin
                start_cyc = cyc;
                n_wr      = 0;
                check("done_clear_at_accept", 32'(b0.done), 32'd0);
                check("res_addr_at_accept", 32'(b0.res_addr), 32'd0);
                check("res_rd_at_accept", 32'(b0.res_rd), 32'd1);
            end
            if (b0.done && !prev_done) begin
                check("done_latency", 32'(cyc - start_cyc), 32'd16385);
                check("write_count", 32'(n_wr), 32'd1024);
                check("busy_at_done", 32'(b0.busy), 32'd0);
                check("res_addr_saturated", 32'(b0.res_addr), 32'd16383);
                check("res_rd_at_done", 32'(b0.res_rd), 32'd0);
                check("done_sync", {30'd0, b1.done, b2.done}, 32'd3);
            end
        end
        prev_busy = b0.busy;
        prev_done = b0.done;
    end

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run_frame(input bit extra_starts);
        int c;
        push_frame();
        pulse_start();
        c = 0;
        while (c < 17000 && !b0.done) begin
            start = (extra_starts && (c % 3000 == 1500)) ? 1'b1 : 1'b0;
            @(negedge clk);
            c++;
        end
        start = 1'b0;
        if (!b0.done) check("done_timeout", 32'd0, 32'd1);
        repeat (5) @(negedge clk);
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("done_held", 32'(b0.done), 32'd1);
        exp_q.delete();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pick [8];
        pick[0] = 8'd0;   pick[1] = 8'd1;   pick[2] = 8'd2;   pick[3] = 8'd3;
        pick[4] = 8'd4;   pick[5] = 8'd5;   pick[6] = 8'd254; pick[7] = 8'd255;

        for (int a = 0; a < 16384; a++) mem[a] = 8'd0;
        mem[16 * 5 + 3] = 8'd7;

        // Reset with start held high: reset must win.
        reset = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", {29'd0, b0.busy, b1.busy, b2.busy}, 32'd0);
        check("rst_done", {29'd0, b0.done, b1.done, b2.done}, 32'd0);
        check("rst_res_rd", {29'd0, b0.res_rd, b1.res_rd, b2.res_rd}, 32'd0);
        check("rst_sti_wr", {29'd0, b0.sti_wr, b1.sti_wr, b2.sti_wr}, 32'd0);
        check("rst_res_addr", 32'(b0.res_addr), 32'd0);
        check("rst_sti_addr", 32'(b0.sti_addr), 32'd0);
        check("rst_sti_do", 32'(b0.sti_do), 32'd0);
        start = 1'b0;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_no_busy", 32'(b0.busy), 32'd0);

        // Frame 1: single pixel res[83]=7, from IDLE.
        run_frame(1'b0);

        // Frame 2: res[a] = a mod 16, started from FIN.
        for (int a = 0; a < 16384; a++) mem[a] = 8'(a % 16);
        run_frame(1'b0);

        // Frame 3: random image aborted by reset 100 cycles in.
        for (int a = 0; a < 16384; a++) mem[a] = 8'($urandom_range(0, 255));
        push_frame();
        pulse_start();
        repeat (100) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {29'd0, b0.busy, b1.busy, b2.busy}, 32'd0);
        check("abort_done", {29'd0, b0.done, b1.done, b2.done}, 32'd0);
        check("abort_sti_wr", {29'd0, b0.sti_wr, b1.sti_wr, b2.sti_wr}, 32'd0);
        exp_q.delete();
        repeat (50) @(negedge clk);

        // Frame 4: boundary-rich random image with extra starts while busy.
        for (int a = 0; a < 16384; a++) begin
            if ($urandom_range(0, 1) == 0) mem[a] = pick[$urandom_range(0, 7)];
            else                           mem[a] = 8'($urandom_range(0, 255));
        end
        run_frame(1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
